// File: rtl/mips_wb_trace_pkg.sv
// Shared types and record layout for the MIPS write-back trace buffer.
// A trace record packs {kind, pc, addr, data} into one REC_W-bit FIFO word.
package trace_pkg;

    localparam logic KIND_GRF = 1'b0;
    localparam logic KIND_DM  = 1'b1;

    localparam int unsigned REC_W = 97;

    // Field offsets (LSB position) within the packed record
    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned ADDR_LSB = 32;
    localparam int unsigned PC_LSB   = 64;
    localparam int unsigned KIND_LSB = 96;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_rec_t;

    function automatic logic [REC_W-1:0] pack_rec(input logic kind, input logic [31:0] pc,
                                                  input logic [31:0] addr,
                                                  input logic [31:0] data);
        trace_rec_t r;
        r.kind = kind;
        r.pc   = pc;
        r.addr = addr;
        r.data = data;
        return r;
    endfunction

endpackage

// File: rtl/mips_wb_trace_if.sv
// Bundle of core write-event taps and the trace output stream.
// The trace block uses the slave modport; the core/consumer side uses master.
interface mips_wb_trace_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             grf_we;
    logic [4:0]       grf_addr;
    logic [31:0]      grf_wdata;
    logic             dm_we;
    logic [31:0]      dm_addr;
    logic [31:0]      dm_wdata;
    logic [31:0]      pc;

    logic             out_valid;
    logic             out_ready;
    logic             out_kind;
    logic [31:0]      out_pc;
    logic [31:0]      out_addr;
    logic [31:0]      out_data;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [CNT_W-1:0] dropped;

    modport slave (
        input  grf_we, grf_addr, grf_wdata, dm_we, dm_addr, dm_wdata, pc, out_ready,
        output out_valid, out_kind, out_pc, out_addr, out_data, count, overflow, dropped
    );

    modport master (
        output grf_we, grf_addr, grf_wdata, dm_we, dm_addr, dm_wdata, pc, out_ready,
        input  out_valid, out_kind, out_pc, out_addr, out_data, count, overflow, dropped
    );

endinterface

// File: rtl/mips_wb_trace_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// Occupancy is held in an explicit counter; pointers simply wrap.
module trace_fifo #(
    parameter int unsigned WIDTH = 97,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        // Next head is either the word being written this cycle or one already stored;
        // when the FIFO goes empty the head keeps the last-read word.
        if (cnt_d != '0) begin
            head_d = (do_push && (rd_d == wr_q)) ? din : mem[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && do_push) mem[wr_q] <= din;
    end

    assign dout  = head_q;
    assign count = cnt_q;

endmodule

// File: rtl/mips_wb_trace.sv
// Captures GRF writes and DM stores from the single-cycle MIPS core into a trace FIFO.
// One event is accepted per cycle; every lost event is counted and flags overflow.
module mips_wb_trace
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    mips_wb_trace_if.slave  bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             grf_ev, dm_ev, ev;
    logic [REC_W-1:0] rec_in, rec_out;
    trace_rec_t       head;
    logic             fifo_full, fifo_empty, pop;
    logic [CW-1:0]    fifo_count;
    logic [1:0]       drop_inc;
    logic [CNT_W:0]   drop_sum;
    logic [CNT_W-1:0] dropped_q, dropped_d;
    logic             overflow_q, overflow_d;

    assign grf_ev = bus.grf_we && (bus.grf_addr != 5'd0);
    assign dm_ev  = bus.dm_we;
    assign ev     = grf_ev || dm_ev;
    assign pop    = bus.out_valid && bus.out_ready;

    assign rec_in = grf_ev ? pack_rec(KIND_GRF, bus.pc, {27'd0, bus.grf_addr}, bus.grf_wdata)
                           : pack_rec(KIND_DM, bus.pc, bus.dm_addr, bus.dm_wdata);

    trace_fifo #(
        .WIDTH(REC_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ev),
        .pop   (pop),
        .din   (rec_in),
        .dout  (rec_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A collision loses the DM store; a full FIFO with no pop also loses the winner.
    always_comb begin
        drop_inc   = 2'd0;
        if (grf_ev && dm_ev) drop_inc = drop_inc + 2'd1;
        if (ev && fifo_full && !pop) drop_inc = drop_inc + 2'd1;
        drop_sum   = {1'b0, dropped_q} + (CNT_W + 1)'(drop_inc);
        dropped_d  = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        overflow_d = overflow_q || (drop_inc != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
        end
    end

    assign head          = rec_out;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_kind  = head.kind;
    assign bus.out_pc    = head.pc;
    assign bus.out_addr  = head.addr;
    assign bus.out_data  = head.data;
    assign bus.count     = fifo_count;
    assign bus.overflow  = overflow_q;
    assign bus.dropped   = dropped_q;

endmodule

// File: tb/tb_mips_wb_trace.sv
// Directed self-checking bench for mips_wb_trace with hand-computed expectations.
module tb_mips_wb_trace;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mips_wb_trace_if #(.DEPTH(16), .CNT_W(16)) bus ();

    mips_wb_trace #(
        .DEPTH(16),
        .CNT_W(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.grf_we    = 1'b0;
        bus.grf_addr  = 5'd0;
        bus.grf_wdata = 32'd0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = 32'd0;
        bus.dm_wdata  = 32'd0;
        bus.pc        = 32'd0;
    endtask

    task automatic grf_event(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        bus.grf_we    = 1'b1;
        bus.grf_addr  = a;
        bus.grf_wdata = d;
        bus.pc        = p;
    endtask

    task automatic dm_event(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        bus.dm_we    = 1'b1;
        bus.dm_addr  = a;
        bus.dm_wdata = d;
        bus.pc       = p;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b0;
        bus.out_ready = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_dropped", 32'(bus.dropped), 32'd0);
        check("rst_pc", bus.out_pc, 32'd0);
        check("rst_data", bus.out_data, 32'd0);
        reset = 1'b1;
        tick();

        // Single GRF write
        grf_event(5'd5, 32'h1234, 32'h3000);
        tick();
        idle_inputs();
        check("grf_valid", 32'(bus.out_valid), 32'd1);
        check("grf_kind", 32'(bus.out_kind), 32'd0);
        check("grf_addr", bus.out_addr, 32'd5);
        check("grf_data", bus.out_data, 32'h1234);
        check("grf_pc", bus.out_pc, 32'h3000);
        check("grf_count", 32'(bus.count), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("grf_pop_count", 32'(bus.count), 32'd0);
        check("grf_pop_valid", 32'(bus.out_valid), 32'd0);

        // Write to $0 is filtered
        grf_event(5'd0, 32'hdead, 32'h3004);
        tick();
        idle_inputs();
        check("r0_count", 32'(bus.count), 32'd0);
        check("r0_dropped", 32'(bus.dropped), 32'd0);
        check("r0_valid", 32'(bus.out_valid), 32'd0);

        // 17 stores into a 16-deep FIFO: the last is dropped
        for (int i = 0; i < 17; i++) begin
            dm_event(32'(4 * i), 32'(100 + i), 32'(32'h4000 + 4 * i));
            tick();
        end
        idle_inputs();
        check("fill_count", 32'(bus.count), 32'd16);
        check("fill_dropped", 32'(bus.dropped), 32'd1);
        check("fill_overflow", 32'(bus.overflow), 32'd1);
        check("fill_head_kind", 32'(bus.out_kind), 32'd1);
        check("fill_head_data", bus.out_data, 32'd100);

        // Full, pop and new event together: accepted, no drop
        check("drain_addr_0", bus.out_addr, 32'h0);
        dm_event(32'h100, 32'h55, 32'h5000);
        bus.out_ready = 1'b1;
        tick();
        idle_inputs();
        check("fullpp_count", 32'(bus.count), 32'd16);
        check("fullpp_dropped", 32'(bus.dropped), 32'd1);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain_addr_%0d", i), bus.out_addr, 32'(4 * i));
            tick();
        end
        check("drain_last_addr", bus.out_addr, 32'h100);
        check("drain_last_pc", bus.out_pc, 32'h5000);
        tick();
        bus.out_ready = 1'b0;
        check("drain_count", 32'(bus.count), 32'd0);
        check("drain_valid", 32'(bus.out_valid), 32'd0);

        // GRF and DM in the same cycle: GRF wins, DM counted as dropped
        grf_event(5'd3, 32'haa, 32'h3008);
        dm_event(32'h200, 32'hbb, 32'h3008);
        tick();
        idle_inputs();
        check("coll_count", 32'(bus.count), 32'd1);
        check("coll_kind", 32'(bus.out_kind), 32'd0);
        check("coll_addr", bus.out_addr, 32'd3);
        check("coll_data", bus.out_data, 32'haa);
        check("coll_dropped", 32'(bus.dropped), 32'd2);

        // Push and pop together on a non-empty FIFO
        grf_event(5'd7, 32'hcc, 32'h300c);
        bus.out_ready = 1'b1;
        tick();
        idle_inputs();
        bus.out_ready = 1'b0;
        check("pp_count", 32'(bus.count), 32'd1);
        check("pp_addr", bus.out_addr, 32'd7);
        check("pp_data", bus.out_data, 32'hcc);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset with 5 buffered records and an event on the reset edge
        for (int i = 1; i <= 5; i++) begin
            grf_event(5'(i), 32'(i), 32'(32'h6000 + 4 * i));
            tick();
        end
        idle_inputs();
        check("pre_rst_count", 32'(bus.count), 32'd5);
        reset = 1'b0;
        grf_event(5'd9, 32'h99, 32'h7000);
        tick();
        reset = 1'b1;
        idle_inputs();
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_overflow", 32'(bus.overflow), 32'd0);
        check("mid_rst_dropped", 32'(bus.dropped), 32'd0);
        tick();
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        check("post_rst_count", 32'(bus.count), 32'd0);

        // Fresh record after reset comes out intact
        dm_event(32'h44, 32'h12345678, 32'h8000);
        tick();
        idle_inputs();
        check("after_rst_valid", 32'(bus.out_valid), 32'd1);
        check("after_rst_addr", bus.out_addr, 32'h44);
        check("after_rst_data", bus.out_data, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_wb_trace.md
# mips_wb_trace

Captures the architectural write events of the single-cycle MIPS core (GRF writes and DM stores) and buffers them in an on-chip FIFO for a downstream reader such as a trace printer, comparator or UART bridge. It sits beside the `mips` core, tapping its write-back and memory-write signals. It absorbs one event per cycle and drains through a valid/ready stream, so a slow consumer never stalls the core. Lost events are counted and flagged, never silently discarded.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `CNT_W`, 16: width of the dropped-event counter.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-low; `reset == 0` at a rising edge clears all state.
- `grf_we` input 1: core GRF write enable this cycle.
- `grf_addr` input 5: GRF destination register.
- `grf_wdata` input 32: GRF write data.
- `dm_we` input 1: core data-memory store enable this cycle.
- `dm_addr` input 32: store byte address.
- `dm_wdata` input 32: store data.
- `pc` input 32: PC of the instruction producing the event.
- `out_valid` output 1: head record present.
- `out_ready` input 1: consumer accepts the head record.
- `out_kind` output 1: 0 = GRF write, 1 = DM store.
- `out_pc` output 32: record PC.
- `out_addr` output 32: register number zero-extended (GRF) or byte address (DM).
- `out_data` output 32: write data.
- `count` output $clog2(DEPTH)+1: current occupancy.
- `overflow` output 1: sticky; set on the first dropped event.
- `dropped` output CNT_W: number of dropped events, saturating.

## Operation
- Event qualification:
  - GRF event = `grf_we && grf_addr != 0`. Writes to $0 are filtered and not counted.
  - DM event = `dm_we`.
- Only one event is enqueued per cycle.
  - If GRF and DM events occur in the same cycle, the GRF event wins.
  - The DM event is then treated as dropped: it increments `dropped` and sets `overflow`.
- Push when an event is present and the FIFO is not full, or when the FIFO is full and a pop occurs in the same cycle.
- Pop when `out_valid && out_ready`.
- Full with no pop: the event is dropped, `dropped` increments (saturating at all-ones) and `overflow` sets.
- Empty: `out_valid = 0`. `out_*` payload holds the last-read value and must not be relied on.
- Simultaneous push and pop when not empty: `count` is unchanged.
  - An empty FIFO never pops, so a push into empty yields `count = 1`.
- Pointers are ADDR_W = $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by `count`, not pointer compare.
- Records stay in FIFO order; the payload is captured exactly as presented, with no arithmetic on it.
- Reset values: `out_valid = 0`, `count = 0`, `overflow = 0`, `dropped = 0`, pointers 0, payload outputs 0.
- Reset mid-operation discards all buffered records. Events in the reset cycle are ignored.

## Timing
- Event sampled at edge N appears as head data with `out_valid = 1` after edge N, when the FIFO was empty. This is first-word fall-through with one-cycle latency.
- A record popped at edge N exposes the next record after edge N, with no bubble.
- `out_valid` and the payload hold stable while `out_ready = 0`.
- `count`, `overflow` and `dropped` update at the same edge as the push, pop or drop that changes them.
- Sustained throughput: one record per cycle in and out.

## Structure
- Package `trace_pkg` holds:
  - `KIND_GRF = 1'b0`, `KIND_DM = 1'b1`;
  - record width `REC_W = 97` (kind + pc + addr + data);
  - field offsets within the packed record.
- Sub-module `trace_fifo`: generic synchronous FWFT FIFO over `REC_W`-bit words with push/pop/full/empty/count.
- The top level does qualification, arbitration, the drop counter and the overflow flag.

## Test plan
- Single GRF write, `grf_addr = 5`, `grf_wdata = 0x1234`, `pc = 0x3000`:
  - next cycle `out_valid = 1`, kind 0, addr 5, data 0x1234, pc 0x3000;
  - pop with `out_ready = 1` gives `count = 0`.
- `grf_we` with `grf_addr = 0`: no record, `count` stays 0, `dropped` stays 0.
- `out_ready = 0`, 17 consecutive DM stores at addr 0x0, 0x4, …, 0x40:
  - `count = 16`, `dropped = 1`, `overflow = 1`;
  - draining returns addresses 0x0 to 0x3C in order.
- FIFO full with `out_ready = 1` and a new event in the same cycle: event accepted, `count` stays 16, `dropped` unchanged.
- Simultaneous `grf_we` (addr 3) and `dm_we`: one kind-0 record enqueued, `dropped` increments by 1.
- Reset (`reset = 0`) for one cycle with 5 buffered records:
  - after the edge `count = 0`, `out_valid = 0`, `overflow = 0`, `dropped = 0`;
  - an event sampled on the reset edge is not stored.
